dmem_access_ctrl: RTL

Sequencing controller for the byte-wide data memory array (1024 × 8-bit, synchronous read, write-enable port). It sits between the MIPS core's load/store stage and the RAM. It accepts one byte, halfword or word request per handshake and walks the RAM one byte per cycle in big-endian order. Load results are assembled and sign- or zero-extended, and the block returns a single-cycle response pulse with an optional fault flag.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_access_ctrl_if.sv | 26 ++
 rtl/dmem_load_extend.sv | 20 ++
 rtl/dmem_access_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access controller: size encodings, FSM states
// and the address/byte-count helpers used by the request capture logic.
package dmem_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DRAIN,
    ST_RESP
  } state_e;

  // Index of the last byte of an access (N-1).
  function automatic logic [1:0] last_idx(input size_e s);
    case (s)
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Low address bits that survive natural alignment for a given size.
  function automatic logic [1:0] keep_low(input size_e s);
    case (s)
      SZ_BYTE: return 2'b11;
      SZ_HALF: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input size_e s, input logic [1:0] low);
    return |(low & ~keep_low(s));
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response channel between the load/store stage (master) and the
// data-memory access controller (slave).
interface dmem_access_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/dmem_load_extend.sv
// Combinational sign/zero extension of the assembled load accumulator to 32 bits.
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] acc_i,
  input  size_e       size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = acc_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & acc_i[7]}}, acc_i[7:0]};
      SZ_HALF: data_o = {{16{signed_i & acc_i[15]}}, acc_i[15:0]};
      default: data_o = acc_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Byte-serial, big-endian sequencer between the load/store stage and a 1-byte-wide
// synchronous RAM. Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word requests.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e            state_q;
  logic              ready_q;
  logic [ADDR_W-1:0] base_q;
  size_e             size_q;
  logic              write_q;
  logic              signed_q;
  logic [31:0]       sdata_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic              cap_q;
  logic [31:0]       acc_q;
  logic [31:0]       acc_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [7:0]        mem_wdata_q;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic [31:0]       rsp_rdata_q;

  size_e             req_size;
  logic              hs;
  logic              req_fault;
  logic [1:0]        req_last;
  logic [ADDR_W-1:0] req_base;
  logic [4:0]        wshift;
  logic [31:0]       req_wdata_al;
  logic [31:0]       ext_data;

  assign req_size = size_e'(bus.req_size);
  assign hs       = bus.req_valid && ready_q;
  assign req_last = last_idx(req_size);
  assign req_base = {bus.req_addr[ADDR_W-1:2], bus.req_addr[1:0] & keep_low(req_size)};

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_fault = (req_size == SZ_RSVD) || misaligned(req_size, bus.req_addr[1:0]);
`else
  assign req_fault = (req_size == SZ_RSVD);
`endif

  // Left-justify store data so the byte for the lowest address sits in [31:24].
  assign wshift       = {2'(2'd3 - req_last), 3'b000};
  assign req_wdata_al = bus.req_wdata << wshift;

  // The final load byte arrives during DRAIN; extend the value being captured.
  assign acc_d = cap_q ? {acc_q[23:0], mem_rdata} : acc_q;

  dmem_load_extend u_extend (
    .acc_i    (acc_d),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  // NOTE: all state, including the RAM-facing outputs, is cleared asynchronously
  // so mem_we drops the instant rst rises, even in the middle of a store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      base_q      <= '0;
      size_q      <= SZ_BYTE;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      sdata_q     <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      cap_q       <= 1'b0;
      acc_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cap_q       <= (state_q == ST_ACCESS) && !write_q;
      acc_q       <= acc_d;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;

      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (hs) begin
            ready_q  <= 1'b0;
            base_q   <= req_base;
            size_q   <= req_size;
            write_q  <= bus.req_write;
            signed_q <= bus.req_signed;
            last_q   <= req_last;
            idx_q    <= '0;
            acc_q    <= '0;
            if (req_fault) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
            end else begin
              state_q     <= ST_ACCESS;
              mem_addr_q  <= req_base;
              mem_we_q    <= bus.req_write;
              mem_wdata_q <= bus.req_write ? req_wdata_al[31:24] : 8'h00;
              sdata_q     <= req_wdata_al << 8;
            end
          end
        end

        ST_ACCESS: begin
          if (idx_q == last_q) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if (write_q) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            idx_q       <= idx_q + 2'd1;
            mem_addr_q  <= base_q + ADDR_W'(idx_q + 2'd1);
            mem_wdata_q <= write_q ? sdata_q[31:24] : 8'h00;
            sdata_q     <= sdata_q << 8;
          end
        end

        ST_DRAIN: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ext_data;
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
